// File: rtl/dual_req_ram_arbiter_if.sv
// dual_req_ram_arbiter_if
//   Requester-side bus of the dual-requester RAM arbiter.
//   Carries both requesters' command fields, the per-port grants, the
//   per-port read-return strobes and the shared read data.
//   master : driven by the requesters (req/we/addr/wdata out; gnt/rvalid/rdata in)
//   slave  : seen by the arbiter   (req/we/addr/wdata in;  gnt/rvalid/rdata out)
interface dual_req_ram_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              req_a;
  logic              req_b;
  logic              we_a;
  logic              we_b;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_a;
  logic [DATA_W-1:0] wdata_b;
  logic              gnt_a;
  logic              gnt_b;
  logic              rvalid_a;
  logic              rvalid_b;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata
  );

  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata
  );
endinterface

// File: rtl/dual_req_ram_arbiter.sv
// dual_req_ram_arbiter
//   Shares one external single-port synchronous RAM between requesters A and B.
//   One access is granted per cycle; the winning command is registered onto
//   the RAM port and read data is returned with a per-port one-cycle strobe.
//
//   Arbitration: round-robin between A and B by default. When the macro
//   ARB_FIXED_PRIO_EN is defined, A always wins contention (B may starve).
//
//   Ports
//     clk          in   rising-edge clock
//     rst_n        in   asynchronous reset, active low
//     bus          slave modport of dual_req_ram_arbiter_if
//                  (req/we/addr/wdata per port in; gnt/rvalid per port and
//                   shared rdata out)
//     ram_data     out  RAM write data
//     ram_address  out  RAM address
//     ram_wr       out  RAM write enable
//     ram_q        in   RAM read data, valid one edge after the RAM samples
//
//   Timing for an accept at edge k:
//     k..k+1   command presented on the RAM port
//     k+1      RAM samples the command
//     k+2..k+3 rvalid_<owner> high, rdata = ram_q (reads only)
module dual_req_ram_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  dual_req_ram_arbiter_if.slave   bus,
  output logic [DATA_W-1:0]       ram_data,
  output logic [ADDR_W-1:0]       ram_address,
  output logic                    ram_wr,
  input  logic [DATA_W-1:0]       ram_q
);

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

  // Arbitration pointer: the port that won the most recent accept.
  owner_t last_owner;
  owner_t last_owner_nxt;

  logic   sel_a;
  logic   sel_b;
  logic   accept;
  owner_t winner;

  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  // Read tag pipeline: tag0 travels with the command stage, tag1/tag2 form
  // the shift register that lines the tag up with ram_q.
  logic   tag0_v;
  logic   tag1_v;
  logic   tag2_v;
  owner_t tag0_own;
  owner_t tag1_own;
  owner_t tag2_own;

  // ---------------------------------------------------------------------------
  // Pointer register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= OWN_B;
    end else begin
      last_owner <= last_owner_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration and pointer next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_a          = 1'b0;
    sel_b          = 1'b0;
    last_owner_nxt = last_owner;

`ifdef ARB_FIXED_PRIO_EN
    if (bus.req_a) begin
      sel_a = 1'b1;
    end else if (bus.req_b) begin
      sel_b = 1'b1;
    end
`else
    if (bus.req_a && bus.req_b) begin
      if (last_owner == OWN_B) begin
        sel_a = 1'b1;
      end else begin
        sel_b = 1'b1;
      end
    end else if (bus.req_a) begin
      sel_a = 1'b1;
    end else if (bus.req_b) begin
      sel_b = 1'b1;
    end
`endif

    // The pointer tracks the winner in both builds; idle cycles leave it alone.
    if (sel_a) begin
      last_owner_nxt = OWN_A;
    end else if (sel_b) begin
      last_owner_nxt = OWN_B;
    end
  end

  // Grants are masked by rst_n so they read low while reset is asserted.
  assign bus.gnt_a = sel_a & rst_n;
  assign bus.gnt_b = sel_b & rst_n;

  // gnt implies req, so an accept is simply a grant at the clock edge.
  assign accept = bus.gnt_a | bus.gnt_b;
  assign winner = sel_a ? OWN_A : OWN_B;

  // ---------------------------------------------------------------------------
  // Winning command mux
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_we    = bus.we_b;
    cmd_addr  = bus.addr_b;
    cmd_wdata = bus.wdata_b;
    if (sel_a) begin
      cmd_we    = bus.we_a;
      cmd_addr  = bus.addr_a;
      cmd_wdata = bus.wdata_a;
    end
  end

  // ---------------------------------------------------------------------------
  // Command stage: RAM port registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_wr      <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
    end else begin
      ram_wr <= accept & cmd_we;
      if (accept) begin
        ram_address <= cmd_addr;
        ram_data    <= cmd_wdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read tag pipeline
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag0_v   <= 1'b0;
      tag1_v   <= 1'b0;
      tag2_v   <= 1'b0;
      tag0_own <= OWN_A;
      tag1_own <= OWN_A;
      tag2_own <= OWN_A;
    end else begin
      tag0_v   <= accept & ~cmd_we;
      tag0_own <= winner;
      tag1_v   <= tag0_v;
      tag1_own <= tag0_own;
      tag2_v   <= tag1_v;
      tag2_own <= tag1_own;
    end
  end

  assign bus.rvalid_a = tag2_v & (tag2_own == OWN_A);
  assign bus.rvalid_b = tag2_v & (tag2_own == OWN_B);
  assign bus.rdata    = ram_q;

endmodule

// File: tb/tb_dual_req_ram_arbiter.sv
module tb_dual_req_ram_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] ram_data;
  logic [7:0] ram_address;
  logic       ram_wr;
  logic [7:0] ram_q;

  int tests_run;
  int tests_failed;
  int cyc_n;

  dual_req_ram_arbiter_if #(.DATA_W(8), .ADDR_W(8)) bus_if ();

  dual_req_ram_arbiter #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_if),
    .ram_data    (ram_data),
    .ram_address (ram_address),
    .ram_wr      (ram_wr),
    .ram_q       (ram_q)
  );

  // RAM model: samples address/write one edge after the arbiter presents
  // them, returns q one edge after that.
  logic [7:0] mem [0:255];
  logic [7:0] ram_addr_q;
  always @(posedge clk) begin
    if (ram_wr) mem[ram_address] <= ram_data;
    ram_addr_q <= ram_address;
    ram_q      <= mem[ram_addr_q];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Per-cycle history sampled at the falling edge, indexed by edge count.
  logic       gnt_a_h    [0:255];
  logic       gnt_b_h    [0:255];
  logic       ram_wr_h   [0:255];
  logic [7:0] ram_addr_h [0:255];
  logic [7:0] ram_data_h [0:255];
  logic       rvalid_a_h [0:255];
  logic       rvalid_b_h [0:255];
  logic [7:0] rdata_h    [0:255];

  always @(negedge clk) begin
    if (cyc_n < 256) begin
      gnt_a_h[cyc_n]    = bus_if.gnt_a;
      gnt_b_h[cyc_n]    = bus_if.gnt_b;
      ram_wr_h[cyc_n]   = ram_wr;
      ram_addr_h[cyc_n] = ram_address;
      ram_data_h[cyc_n] = ram_data;
      rvalid_a_h[cyc_n] = bus_if.rvalid_a;
      rvalid_b_h[cyc_n] = bus_if.rvalid_b;
      rdata_h[cyc_n]    = bus_if.rdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.req_a   = 1'b0;
    bus_if.req_b   = 1'b0;
    bus_if.we_a    = 1'b0;
    bus_if.we_b    = 1'b0;
    bus_if.addr_a  = 8'h00;
    bus_if.addr_b  = 8'h00;
    bus_if.wdata_a = 8'h00;
    bus_if.wdata_b = 8'h00;
  endtask

  task automatic drive_a(input logic we, input logic [7:0] addr, input logic [7:0] wd);
    bus_if.req_a   = 1'b1;
    bus_if.we_a    = we;
    bus_if.addr_a  = addr;
    bus_if.wdata_a = wd;
  endtask

  task automatic drive_b(input logic we, input logic [7:0] addr, input logic [7:0] wd);
    bus_if.req_b   = 1'b1;
    bus_if.we_b    = we;
    bus_if.addr_b  = addr;
    bus_if.wdata_b = wd;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    bus_if.req_a = 1'b1;
    bus_if.req_b = 1'b1;
    tick();
    tick();
    #3;
    tests_run++;
    if (bus_if.gnt_a !== 1'b0) begin
      tests_failed++; $display("FAIL reset_gnt_a: got %b expected 0", bus_if.gnt_a);
    end
    tests_run++;
    if (bus_if.gnt_b !== 1'b0) begin
      tests_failed++; $display("FAIL reset_gnt_b: got %b expected 0", bus_if.gnt_b);
    end
    tests_run++;
    if (ram_wr !== 1'b0) begin
      tests_failed++; $display("FAIL reset_ram_wr: got %b expected 0", ram_wr);
    end
    tests_run++;
    if (bus_if.rvalid_a !== 1'b0 || bus_if.rvalid_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_rvalid: got a=%b b=%b expected 0/0", bus_if.rvalid_a, bus_if.rvalid_b);
    end
    tests_run++;
    if (ram_address !== 8'h00 || ram_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_ram_port: got addr=%h data=%h expected 00/00", ram_address, ram_data);
    end
    tick();
    rst_n = 1'b1;
    #2;
    tests_run++;
    if (bus_if.gnt_a !== 1'b1 || bus_if.gnt_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_first_grant: got a=%b b=%b expected 1/0", bus_if.gnt_a, bus_if.gnt_b);
    end
    idle_inputs();
    repeat (3) tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single_writer();
    int c0;
    logic [7:0] wr_addr [3];
    logic [7:0] wr_val  [3];
    logic [7:0] rd_exp  [3];
    wr_addr = '{8'd70, 8'd64, 8'd127};
    wr_val  = '{8'h4A, 8'hC0, 8'h6F};
    rd_exp  = '{8'hC0, 8'h4A, 8'h6F};
    c0 = cyc_n;
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, wr_addr[i], wr_val[i]);
      tick();
    end
    drive_a(1'b0, 8'd64, 8'h00);  tick();
    drive_a(1'b0, 8'd70, 8'h00);  tick();
    drive_a(1'b0, 8'd127, 8'h00); tick();
    idle_inputs();
    repeat (6) tick();

    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (gnt_a_h[c0+i] !== 1'b1 || gnt_b_h[c0+i] !== 1'b0) begin
        tests_failed++;
        $display("FAIL single_gnt[%0d]: got a=%b b=%b expected 1/0", i, gnt_a_h[c0+i], gnt_b_h[c0+i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (ram_wr_h[c0+1+i] !== 1'b1 || ram_addr_h[c0+1+i] !== wr_addr[i] ||
          ram_data_h[c0+1+i] !== wr_val[i]) begin
        tests_failed++;
        $display("FAIL single_wr_cmd[%0d]: got wr=%b addr=%h data=%h expected 1/%h/%h", i,
                 ram_wr_h[c0+1+i], ram_addr_h[c0+1+i], ram_data_h[c0+1+i], wr_addr[i], wr_val[i]);
      end
    end
    tests_run++;
    if (ram_wr_h[c0+4] !== 1'b0) begin
      tests_failed++; $display("FAIL single_rd_no_wr: got %b expected 0", ram_wr_h[c0+4]);
    end
    tests_run++;
    if (rvalid_a_h[c0+5] !== 1'b0 || rvalid_a_h[c0+9] !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_rvalid_edges: got before=%b after=%b expected 0/0",
               rvalid_a_h[c0+5], rvalid_a_h[c0+9]);
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (rvalid_a_h[c0+6+i] !== 1'b1 || rvalid_b_h[c0+6+i] !== 1'b0 ||
          rdata_h[c0+6+i] !== rd_exp[i]) begin
        tests_failed++;
        $display("FAIL single_read[%0d]: got va=%b vb=%b rdata=%h expected 1/0/%h", i,
                 rvalid_a_h[c0+6+i], rvalid_b_h[c0+6+i], rdata_h[c0+6+i], rd_exp[i]);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_contention();
    int c0;
    logic       exp_a;
    logic [7:0] exp_d;
    // A single B write first makes B the last owner, so A wins the first round.
    drive_b(1'b1, 8'd200, 8'h33);
    tick();
    idle_inputs();
    c0 = cyc_n;
    drive_a(1'b0, 8'd70, 8'h00);
    drive_b(1'b0, 8'd64, 8'h00);
    repeat (4) tick();
    idle_inputs();
    repeat (6) tick();

    for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      exp_a = 1'b1;
`else
      exp_a = (i % 2 == 0);
`endif
      exp_d = exp_a ? 8'h4A : 8'hC0;
      tests_run++;
      if (gnt_a_h[c0+i] !== exp_a || gnt_b_h[c0+i] !== ~exp_a) begin
        tests_failed++;
        $display("FAIL contention_gnt[%0d]: got a=%b b=%b expected %b/%b", i,
                 gnt_a_h[c0+i], gnt_b_h[c0+i], exp_a, ~exp_a);
      end
      tests_run++;
      if (rvalid_a_h[c0+3+i] !== exp_a || rvalid_b_h[c0+3+i] !== ~exp_a ||
          rdata_h[c0+3+i] !== exp_d) begin
        tests_failed++;
        $display("FAIL contention_rd[%0d]: got va=%b vb=%b rdata=%h expected %b/%b/%h", i,
                 rvalid_a_h[c0+3+i], rvalid_b_h[c0+3+i], rdata_h[c0+3+i], exp_a, ~exp_a, exp_d);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_raw_hazard();
    int c0;
    c0 = cyc_n;
    drive_b(1'b1, 8'd10, 8'h55);
    tick();
    idle_inputs();
    drive_a(1'b0, 8'd10, 8'h00);
    tick();
    idle_inputs();
    repeat (6) tick();

    tests_run++;
    if (gnt_b_h[c0] !== 1'b1 || gnt_a_h[c0+1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL raw_gnt: got b=%b a=%b expected 1/1", gnt_b_h[c0], gnt_a_h[c0+1]);
    end
    tests_run++;
    if (ram_wr_h[c0+1] !== 1'b1 || ram_wr_h[c0+2] !== 1'b0) begin
      tests_failed++;
      $display("FAIL raw_ram_wr: got %b,%b expected 1,0", ram_wr_h[c0+1], ram_wr_h[c0+2]);
    end
    tests_run++;
    if (rvalid_a_h[c0+3] !== 1'b0) begin
      tests_failed++; $display("FAIL raw_early_rvalid: got %b expected 0", rvalid_a_h[c0+3]);
    end
    tests_run++;
    if (rvalid_a_h[c0+4] !== 1'b1 || rdata_h[c0+4] !== 8'h55) begin
      tests_failed++;
      $display("FAIL raw_read: got va=%b rdata=%h expected 1/55", rvalid_a_h[c0+4], rdata_h[c0+4]);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_read();
    int c0;
    int d0;
    c0 = cyc_n;
    drive_a(1'b0, 8'd70, 8'h00);
    tick();
    idle_inputs();
    drive_b(1'b1, 8'd70, 8'h99);
    tick();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();

    tests_run++;
    if (ram_wr_h[c0+2] !== 1'b0 || ram_wr_h[c0+3] !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_ram_wr: got %b,%b expected 0,0", ram_wr_h[c0+2], ram_wr_h[c0+3]);
    end
    for (int i = 3; i < 6; i++) begin
      tests_run++;
      if (rvalid_a_h[c0+i] !== 1'b0 || rvalid_b_h[c0+i] !== 1'b0) begin
        tests_failed++;
        $display("FAIL rstmid_rvalid[%0d]: got a=%b b=%b expected 0/0", i,
                 rvalid_a_h[c0+i], rvalid_b_h[c0+i]);
      end
    end

    d0 = cyc_n;
    drive_a(1'b0, 8'd70, 8'h00);
    tick();
    idle_inputs();
    repeat (5) tick();
    tests_run++;
    if (rvalid_a_h[d0+3] !== 1'b1 || rdata_h[d0+3] !== 8'h4A) begin
      tests_failed++;
      $display("FAIL rstmid_readback: got va=%b rdata=%h expected 1/4a", rvalid_a_h[d0+3], rdata_h[d0+3]);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_idle();
    int c0;
    logic       exp_a;
    logic [7:0] exp_d;
    c0 = cyc_n;
    idle_inputs();
    repeat (5) tick();
    drive_a(1'b0, 8'd64, 8'h00);
    drive_b(1'b0, 8'd127, 8'h00);
    tick();
    idle_inputs();
    repeat (6) tick();

    for (int i = 1; i <= 5; i++) begin
      tests_run++;
      if (ram_wr_h[c0+i] !== 1'b0 || rvalid_a_h[c0+i] !== 1'b0 || rvalid_b_h[c0+i] !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle_quiet[%0d]: got wr=%b va=%b vb=%b expected 0/0/0", i,
                 ram_wr_h[c0+i], rvalid_a_h[c0+i], rvalid_b_h[c0+i]);
      end
    end
    // A was served last before the idle gap.
`ifdef ARB_FIXED_PRIO_EN
    exp_a = 1'b1;
`else
    exp_a = 1'b0;
`endif
    exp_d = exp_a ? 8'hC0 : 8'h6F;
    tests_run++;
    if (gnt_a_h[c0+5] !== exp_a || gnt_b_h[c0+5] !== ~exp_a) begin
      tests_failed++;
      $display("FAIL idle_next_gnt: got a=%b b=%b expected %b/%b",
               gnt_a_h[c0+5], gnt_b_h[c0+5], exp_a, ~exp_a);
    end
    tests_run++;
    if (rvalid_a_h[c0+8] !== exp_a || rvalid_b_h[c0+8] !== ~exp_a || rdata_h[c0+8] !== exp_d) begin
      tests_failed++;
      $display("FAIL idle_next_read: got va=%b vb=%b rdata=%h expected %b/%b/%h",
               rvalid_a_h[c0+8], rvalid_b_h[c0+8], rdata_h[c0+8], exp_a, ~exp_a, exp_d);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cyc_n        = 0;
    rst_n        = 1'b0;
    idle_inputs();
    test_reset();
    test_single_writer();
    test_contention();
    test_raw_hazard();
    test_reset_mid_read();
    test_idle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
